// File: rtl/bus_wait_responder.sv
// bus_wait_responder: windowed RAM responder with WAIT-cycle RDY stretch; define BUS_WAIT_RESPONDER_WP_EN to write-protect the upper half of the window
module bus_wait_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter int          WAIT      = 2
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic [15:0] A,
  input  logic        R_W,
  input  logic [7:0]  WD,
  output logic [7:0]  RD,
  output logic        RDY,
  output logic        SEL,
  output logic        DONE
);
  localparam logic [3:0] W = 4'(WAIT);
  logic [7:0] ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic [15:0] held_a;
  logic [3:0] cnt, eff;
  logic held_rw, restart, last, wp;
  assign idx = A[ADDR_BITS-1:0];
`ifdef BUS_WAIT_RESPONDER_WP_EN
  assign wp = A[ADDR_BITS-1];
`else
  assign wp = 1'b0;
`endif
  always_comb begin
    SEL = A[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS];
    restart = cnt != 4'd0 && (A != held_a || R_W != held_rw);
    eff = restart ? 4'd0 : cnt;
    last = eff == W;
    RDY = !RES_N || !SEL || last;
    DONE = RES_N && SEL && last;
    RD = SEL && R_W ? ram[idx] : 8'h00;
  end
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      cnt <= 4'd0;
      held_a <= 16'h0000;
      held_rw <= 1'b1;
    end else if (SEL && !last) begin
      cnt <= eff + 4'd1;
      held_a <= A;
      held_rw <= R_W;
    end else
      cnt <= 4'd0;
  always_ff @(posedge CLK)
    if (DONE && !R_W && !wp) ram[idx] <= WD;
endmodule

// File: tb/tb_bus_wait_responder.sv
// tb_bus_wait_responder: vector table plus scoreboard for WAIT=2 responder, and a WAIT=0 instance
module tb_bus_wait_responder;
  logic CLK = 1'b0, RES_N = 1'b0;
  logic [15:0] A = 16'h0000, a0 = 16'h0000;
  logic R_W = 1'b1, rw0 = 1'b1;
  logic [7:0] WD = 8'h00, wd0 = 8'h00;
  logic [7:0] RD, rd0;
  logic RDY, SEL, DONE, rdy0, sel0, done0;
  int total = 0, bad = 0;
  logic [7:0] sb[$];
  typedef struct {logic [15:0] a; logic rw; logic [7:0] wd; logic [7:0] rd;} vec_t;
  vec_t v[14];
  logic [7:0] model[8];
  bus_wait_responder #(.ADDR_BITS(8), .BASE_ADDR(16'hF000), .WAIT(2)) dut (
    .CLK(CLK), .RES_N(RES_N), .A(A), .R_W(R_W), .WD(WD),
    .RD(RD), .RDY(RDY), .SEL(SEL), .DONE(DONE));
  bus_wait_responder #(.ADDR_BITS(8), .BASE_ADDR(16'hF000), .WAIT(0)) dut0 (
    .CLK(CLK), .RES_N(RES_N), .A(a0), .R_W(rw0), .WD(wd0),
    .RD(rd0), .RDY(rdy0), .SEL(sel0), .DONE(done0));
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic do_access(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic [7:0] exp);
    logic hit;
    logic [7:0] e;
    hit = a[15:8] == 8'hF0;
    @(posedge CLK); #1;
    A = a; R_W = rw; WD = wd;
    if (hit && rw) sb.push_back(exp);
    for (int c = 0; c <= 2; c++) begin
      @(negedge CLK);
      chk("sel", {7'd0, SEL}, {7'd0, hit});
      chk("rdy", {7'd0, RDY}, {7'd0, !hit || c == 2});
      chk("done", {7'd0, DONE}, {7'd0, hit && c == 2});
      if (!hit || !rw) chk("rd_idle", RD, 8'h00);
      if (DONE && rw) begin
        if (sb.size() == 0) chk("sb_underflow", 8'h01, 8'h00);
        else begin
          e = sb.pop_front();
          chk("rd", RD, e);
        end
      end
      if (!hit) break;
    end
  endtask
  initial begin
    v[0]  = '{16'hF010, 1'b0, 8'h5A, 8'h00};
    v[1]  = '{16'hF010, 1'b1, 8'h00, 8'h5A};
    v[2]  = '{16'hF000, 1'b0, 8'hA5, 8'h00};
    v[3]  = '{16'hF0FF, 1'b0, 8'h3C, 8'h00};
    v[4]  = '{16'h0200, 1'b0, 8'h99, 8'h00};
    v[5]  = '{16'h0210, 1'b1, 8'h00, 8'h00};
    v[6]  = '{16'hF000, 1'b1, 8'h00, 8'hA5};
    v[7]  = '{16'hF0FF, 1'b1, 8'h00, 8'h3C};
    v[8]  = '{16'hF001, 1'b0, 8'hC3, 8'h00};
    v[9]  = '{16'hF080, 1'b0, 8'hAA, 8'h00};
    v[10] = '{16'hF07F, 1'b0, 8'hBB, 8'h00};
`ifdef BUS_WAIT_RESPONDER_WP_EN
    v[11] = '{16'hF080, 1'b1, 8'h00, 8'h00};
`else
    v[11] = '{16'hF080, 1'b1, 8'h00, 8'hAA};
`endif
    v[12] = '{16'hF07F, 1'b1, 8'h00, 8'hBB};
    v[13] = '{16'hF020, 1'b0, 8'h11, 8'h00};
    A = 16'hF000; R_W = 1'b1;
    #2;
    chk("rst_rdy", {7'd0, RDY}, 8'h01);
    chk("rst_done", {7'd0, DONE}, 8'h00);
    @(posedge CLK); #1;
    chk("rst_rdy_clk", {7'd0, RDY}, 8'h01);
    A = 16'h0000;
    @(negedge CLK);
    RES_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_rdy", {7'd0, RDY}, 8'h01);
    for (int i = 0; i < 14; i++) do_access(v[i].a, v[i].rw, v[i].wd, v[i].rd);
    @(posedge CLK); #1;
    A = 16'hF001; R_W = 1'b1;
    @(negedge CLK);
    chk("rs_rdy0", {7'd0, RDY}, 8'h00);
    do_access(16'hF002, 1'b0, 8'h33, 8'h00);
    do_access(16'hF002, 1'b1, 8'h00, 8'h33);
    do_access(16'hF001, 1'b1, 8'h00, 8'hC3);
    @(posedge CLK); #1;
    A = 16'hF020; R_W = 1'b0; WD = 8'h77;
    @(negedge CLK);
    chk("mr_rdy0", {7'd0, RDY}, 8'h00);
    @(negedge CLK);
    chk("mr_rdy1", {7'd0, RDY}, 8'h00);
    #2 RES_N = 1'b0;
    #1;
    chk("mr_async_rdy", {7'd0, RDY}, 8'h01);
    chk("mr_async_done", {7'd0, DONE}, 8'h00);
    @(posedge CLK); #1;
    A = 16'h0000; R_W = 1'b1;
    @(negedge CLK);
    RES_N = 1'b1;
    do_access(16'hF020, 1'b1, 8'h00, 8'h11);
    A = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      model[i] = 8'($urandom);
      @(posedge CLK); #1;
      a0 = {8'hF0, 8'(i * 37)}; rw0 = 1'b0; wd0 = model[i];
      @(negedge CLK);
      chk("w0_rdy", {7'd0, rdy0}, 8'h01);
      chk("w0_done", {7'd0, done0}, 8'h01);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      a0 = {8'hF0, 8'(i * 37)}; rw0 = 1'b1;
      @(negedge CLK);
      chk("r0_rdy", {7'd0, rdy0}, 8'h01);
      chk("r0_done", {7'd0, done0}, 8'h01);
      chk("r0_rd", rd0, model[i]);
    end
    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
